// File: rtl/alu_issue.sv
// Single-register RV32I issue stage: decodes an instruction into ALU operands/control
// behind a valid/ready register slice. Define ALU_ISSUE_PERF_EN to add o_issue_cnt.

`ifndef ADD
`define ADD  4'd0
`endif
`ifndef SUB
`define SUB  4'd1
`endif
`ifndef AND
`define AND  4'd2
`endif
`ifndef OR
`define OR   4'd3
`endif
`ifndef XOR
`define XOR  4'd4
`endif
`ifndef SRL
`define SRL  4'd5
`endif
`ifndef SLL
`define SLL  4'd6
`endif
`ifndef SRA
`define SRA  4'd7
`endif
`ifndef BUF
`define BUF  4'd8
`endif
`ifndef SLT
`define SLT  4'd9
`endif
`ifndef SLTU
`define SLTU 4'd10
`endif
`ifndef EQ
`define EQ   4'd11
`endif
`ifndef GE
`define GE   4'd12
`endif
`ifndef GEU
`define GEU  4'd13
`endif

module alu_issue #(
    parameter logic [31:0] RESET_PC_OUT = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ex_ready,
    output logic [31:0] o_op1,
    output logic [31:0] o_op2,
    output logic [3:0]  o_AluCtrl,
    output logic [31:0] o_pc,
    output logic [4:0]  o_rd,
    output logic        o_wb_en,
    output logic        o_is_branch,
    output logic        o_br_neg,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0] o_issue_cnt,
`endif
    output logic        o_illegal
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011
    } opcode_t;

    function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_ctrl = alt ? `SUB : `ADD;
            3'b001:  arith_ctrl = `SLL;
            3'b010:  arith_ctrl = `SLT;
            3'b011:  arith_ctrl = `SLTU;
            3'b100:  arith_ctrl = `XOR;
            3'b101:  arith_ctrl = alt ? `SRA : `SRL;
            3'b110:  arith_ctrl = `OR;
            default: arith_ctrl = `AND;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_u, shamt;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];
    assign rd     = i_instr[11:7];
    assign imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
    assign imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign imm_u  = {i_instr[31:12], 12'b0};
    assign shamt  = {27'b0, i_instr[24:20]};

    logic [31:0] d_op1, d_op2;
    logic [3:0]  d_ctrl;
    logic        d_wb, d_br, d_neg, d_ill;

    // NOTE: every decode output gets a default first so no path through the case infers a latch.
    always_comb begin
        d_op1  = i_rs1_data;
        d_op2  = i_rs2_data;
        d_ctrl = `ADD;
        d_wb   = 1'b1;
        d_br   = 1'b0;
        d_neg  = 1'b0;
        d_ill  = 1'b0;
        case (opcode)
            OPC_OP: begin
                d_ctrl = arith_ctrl(funct3, i_instr[30]);
                if (!(funct7 == 7'h00 ||
                      (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    d_ill = 1'b1;
            end
            OPC_OP_IMM: begin
                d_op2 = imm_i;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    d_op2  = shamt;
                    d_ctrl = arith_ctrl(funct3, i_instr[30]);
                    if (!(funct7 == 7'h00 || (funct7 == 7'h20 && funct3 == 3'b101)))
                        d_ill = 1'b1;
                end else begin
                    d_ctrl = arith_ctrl(funct3, 1'b0);
                end
            end
            OPC_LUI: begin
                d_ctrl = `BUF;
                d_op1  = 32'b0;
                d_op2  = imm_u;
            end
            OPC_AUIPC: begin
                d_op1 = i_pc;
                d_op2 = imm_u;
            end
            OPC_LOAD:  d_op2 = imm_i;
            OPC_STORE: begin
                d_op2 = imm_s;
                d_wb  = 1'b0;
            end
            OPC_JAL, OPC_JALR: begin
                d_op1 = i_pc;
                d_op2 = 32'd4;
            end
            OPC_BRANCH: begin
                d_br = 1'b1;
                d_wb = 1'b0;
                case (funct3)
                    3'b000:  d_ctrl = `EQ;
                    3'b001: begin d_ctrl = `EQ;  d_neg = 1'b1; end
                    3'b100:  d_ctrl = `SLT;
                    3'b101:  d_ctrl = `GE;
                    3'b110: begin d_ctrl = `GEU; d_neg = 1'b1; end
                    3'b111:  d_ctrl = `GEU;
                    default: d_ill  = 1'b1;
                endcase
            end
            default: d_ill = 1'b1;
        endcase
        if (i_instr[1:0] != 2'b11)
            d_ill = 1'b1;
        // Illegal instructions still issue, but as an inert ADD of zeros.
        if (d_ill) begin
            d_op1  = 32'b0;
            d_op2  = 32'b0;
            d_ctrl = `ADD;
            d_wb   = 1'b0;
            d_br   = 1'b0;
            d_neg  = 1'b0;
        end
        if (rd == 5'd0)
            d_wb = 1'b0;
    end

    logic accept;
    assign o_ready = !o_valid || i_ex_ready;
    assign accept  = i_valid && o_ready && !i_flush;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_op1       <= 32'b0;
            o_op2       <= 32'b0;
            o_AluCtrl   <= `ADD;
            o_pc        <= RESET_PC_OUT;
            o_rd        <= 5'b0;
            o_wb_en     <= 1'b0;
            o_is_branch <= 1'b0;
            o_br_neg    <= 1'b0;
            o_illegal   <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (accept) begin
            o_valid     <= 1'b1;
            o_op1       <= d_op1;
            o_op2       <= d_op2;
            o_AluCtrl   <= d_ctrl;
            o_pc        <= i_pc;
            o_rd        <= rd;
            o_wb_en     <= d_wb;
            o_is_branch <= d_br;
            o_br_neg    <= d_neg;
            o_illegal   <= d_ill;
        end else if (i_ex_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_issue_cnt <= 32'b0;
        else if (o_valid && i_ex_ready)
            o_issue_cnt <= o_issue_cnt + 32'd1;
    end
`endif

endmodule
